gen_flag_checker: RTL and testbench

Self-checking sequencer that sits directly downstream of the parameterised generate-construct interface. It consumes the interface's seven initialised flag variables and decides whether each generate form (bare generate, generate-begin, if/else, case, for) elaborated for the given PARAM. It waits a settle window after `start`, then requires the flag vector to match the PARAM-derived expectation for a run of consecutive cycles. It reports pass/fail with a sticky mismatch mask, and the test top uses that result to drive `$stop`/`$finish`.

---
 rtl/gen_flag_checker.sv | 195 +++++++++++++++++++
 tb/tb_gen_flag_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gen_flag_checker.sv
// -----------------------------------------------------------------------------
// gen_flag_checker
//
// Purpose:
//   Verdict sequencer for the generate-construct flag interface. After a start
//   it waits SETTLE cycles, then samples the seven flag bits every cycle and
//   compares them with the vector expected for PARAM. STABLE consecutive
//   matches give a pass. Reaching TIMEOUT samples first gives a fail. Every
//   mismatching bit seen while sampling is kept in a sticky mask.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      begin a check (honoured only while idle)
//   flags_i[6:0] {p5,p4_no,p4,p3_no,p3,p2,p1}, bit0 = p1
//   busy_o       high while settling or sampling
//   done_o       one-cycle pulse when the verdict is ready
//   pass_o       verdict, held until the next accepted start
//   fail_mask_o  sticky OR of (flags ^ expected) over all samples
//   samples_o    samples taken in the current/last run (saturates at TIMEOUT)
// -----------------------------------------------------------------------------

// Per-flag lane: mismatch detect plus a sticky mismatch bit.
module gen_flag_checker_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,    // start of a new run
  input  logic smp_i,    // this edge takes a sample
  input  logic flag_i,
  input  logic exp_i,
  output logic mism_o,
  output logic sticky_o
);
  logic sticky_q, sticky_d;

  assign mism_o = flag_i ^ exp_i;

  always_comb begin
    sticky_d = sticky_q;
    if (clr_i)                sticky_d = 1'b0;
    else if (smp_i && mism_o) sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
endmodule

module gen_flag_checker #(
  parameter int PARAM   = 0,
  parameter int SETTLE  = 2,
  parameter int STABLE  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [6:0] flags_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [6:0] fail_mask_o,
  output logic [4:0] samples_o
);
  localparam int NF = 7;
  // PARAM==1 elaborates the "true" arms (p3, p4); otherwise the "else" arms.
  localparam logic [NF-1:0] EXP_VEC = (PARAM == 1) ? 7'b1010111 : 7'b1101011;

  localparam int WW = $clog2(SETTLE + 1);
  localparam int SW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [SW-1:0] stab_q,  stab_d;
  logic [TW-1:0] smp_q,   smp_d;
  logic          pass_q,  pass_d;

  logic          accept;
  logic          sampling;
  logic          match;
  logic          stab_hit;
  logic          tmo_hit;
  logic          settle_end;
  logic [NF-1:0] mism;
  logic [NF-1:0] sticky;

  assign accept     = (state_q == IDLE) && start_i;
  assign sampling   = (state_q == CHECK);
  assign settle_end = (wait_q == WW'(SETTLE - 1));

  // ---------------------------------------------------------------------------
  // Flag lanes
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NF; i++) begin : g_lane
    gen_flag_checker_lane u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (accept),
      .smp_i    (sampling),
      .flag_i   (flags_i[i]),
      .exp_i    (EXP_VEC[i]),
      .mism_o   (mism[i]),
      .sticky_o (sticky[i])
    );
  end

  assign match = ~|mism;

  // The sample that completes the stable run and the TIMEOUT-th sample may
  // coincide; stab_hit is checked first so a pass wins that tie.
  assign stab_hit = match && (stab_q == SW'(STABLE - 1));
  assign tmo_hit  = (smp_q == TW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i)              state_d = WAIT;
      WAIT:  if (settle_end)           state_d = CHECK;
      CHECK: if (stab_hit || tmo_hit)  state_d = DONE;
      DONE:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      WAIT, CHECK: busy_o = 1'b1;
      DONE:        done_o = 1'b1;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and verdict
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_d = wait_q;
    stab_d = stab_q;
    smp_d  = smp_q;
    pass_d = pass_q;
    if (accept) begin
      wait_d = '0;
      stab_d = '0;
      smp_d  = '0;
      pass_d = 1'b0;
    end else if (state_q == WAIT) begin
      wait_d = wait_q + WW'(1);
    end else if (sampling) begin
      if (smp_q != TW'(TIMEOUT)) smp_d = smp_q + TW'(1);
      // Any mismatch restarts the run; the lanes record which bits differed.
      stab_d = match ? stab_q + SW'(1) : '0;
      if (stab_hit) pass_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
      stab_q <= '0;
      smp_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      stab_q <= stab_d;
      smp_q  <= smp_d;
      pass_q <= pass_d;
    end
  end

  assign pass_o      = pass_q;
  assign fail_mask_o = sticky;
  assign samples_o   = 5'(smp_q);
endmodule

// File: tb/tb_gen_flag_checker.sv
module tb_gen_flag_checker;
  localparam int SETTLE  = 2;
  localparam int STABLE  = 3;
  localparam int TIMEOUT = 16;
  localparam logic [6:0] EXP1 = 7'b1010111;  // PARAM==1
  localparam logic [6:0] EXP0 = 7'b1101011;  // PARAM!=1

  typedef struct {
    bit         pass;
    logic [6:0] mask;
    int         n;
    int         edge_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start0 = 1'b0;
  logic [6:0] flags = '0;
  logic       busy1, done1, pass1, busy0, done0, pass0;
  logic [6:0] mask1, mask0;
  logic [4:0] samp1, samp0;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q1[$];
  exp_t q0[$];
  logic [6:0] seq [TIMEOUT];

  gen_flag_checker #(.PARAM(1), .SETTLE(SETTLE), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) u_p1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .flags_i(flags),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_mask_o(mask1), .samples_o(samp1));

  gen_flag_checker #(.PARAM(0), .SETTLE(SETTLE), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) u_p0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .flags_i(flags),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_mask_o(mask0), .samples_o(samp0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: walk the per-sample flag sequence with the verdict rules.
  function automatic exp_t model(input logic [6:0] expv);
    exp_t e;
    int   run_len;
    run_len  = 0;
    e.pass   = 1'b0;
    e.mask   = '0;
    e.n      = TIMEOUT;
    e.edge_n = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (seq[i-1] == expv) run_len++;
      else begin
        run_len = 0;
        e.mask  = e.mask | (seq[i-1] ^ expv);
      end
      if (run_len == STABLE) begin
        e.pass = 1'b1;
        e.n    = i;
        break;
      end
    end
    return e;
  endfunction

  // Monitor: pop and compare whenever a DUT presents done.
  task automatic verdict(input bit sel, input logic p, input logic [6:0] m,
                         input logic [4:0] s, input logic b);
    exp_t e;
    string pre;
    pre = sel ? "p1" : "p0";
    if ((sel ? q1.size() : q0.size()) == 0) begin
      chk({pre, "_unexpected_done"}, 1, 0);
      return;
    end
    e = sel ? q1.pop_front() : q0.pop_front();
    chk({pre, "_pass"},      int'(p), int'(e.pass));
    chk({pre, "_fail_mask"}, int'(m), int'(e.mask));
    chk({pre, "_samples"},   int'(s), e.n);
    chk({pre, "_done_edge"}, cyc,     e.edge_n);
    chk({pre, "_busy_done"}, int'(b), 0);
  endtask

  always @(negedge clk) begin
    if (done1) verdict(1'b1, pass1, mask1, samp1, busy1);
    if (done0) verdict(1'b0, pass0, mask0, samp0, busy0);
  end

  task automatic fill(input logic [6:0] v);
    for (int i = 0; i < TIMEOUT; i++) seq[i] = v;
  endtask

  // One run: start sampled at the next edge k; flags for sample j are
  // presented before edge k+SETTLE+j, random noise elsewhere.
  task automatic run(input bit sel, input bit repulse);
    exp_t e;
    int   k, off, last;
    e        = model(sel ? EXP1 : EXP0);
    k        = cyc + 1;
    e.edge_n = k + SETTLE + e.n;
    if (sel) q1.push_back(e); else q0.push_back(e);
    last = SETTLE + e.n + 1;
    for (int c = 0; c <= last; c++) begin
      off    = c - SETTLE;
      flags  = (off >= 1 && off <= TIMEOUT) ? seq[off-1] : 7'($urandom);
      start1 = sel  && (c == 0 || (repulse && (c == 1 || c == 3)));
      start0 = !sel && (c == 0 || (repulse && (c == 1 || c == 3)));
      @(posedge clk); #1;
      if (c == 0) chk("busy_after_start", int'(sel ? busy1 : busy0), 1);
    end
    start1 = 1'b0;
    start0 = 1'b0;
    chk("verdict_seen", sel ? q1.size() : q0.size(), 0);
    if (sel) q1.delete(); else q0.delete();
    chk("pass_held",    int'(sel ? pass1 : pass0), int'(e.pass));
    chk("samples_held", int'(sel ? samp1 : samp0), e.n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state (asynchronous, before any clock edge).
    #2;
    chk("rst_busy",  int'(busy1), 0);
    chk("rst_done",  int'(done1), 0);
    chk("rst_pass",  int'(pass1), 0);
    chk("rst_mask",  int'(mask1), 0);
    chk("rst_samp",  int'(samp1), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_samp0", int'(samp0), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean pass, both PARAM settings.
    fill(EXP1); run(1'b1, 1'b0);
    fill(EXP0); run(1'b0, 1'b0);
    // Wrong-form flags on PARAM=0: timeout fail.
    fill(EXP1); run(1'b0, 1'b0);
    // p5 glitch on the 2nd sample, then a repulsed run right after done.
    fill(EXP1); seq[1] = EXP1 & 7'b0111111; run(1'b1, 1'b0);
    fill(EXP1); run(1'b1, 1'b1);
    // Nothing initialised.
    fill(7'b0); run(1'b1, 1'b0);

    // Reset during CHECK, with a mismatch already recorded.
    fill(EXP1); seq[0] = EXP1 ^ 7'b0000001;
    k = cyc + 1;
    for (int c = 0; c <= 3; c++) begin
      flags  = (c - SETTLE >= 1) ? seq[c-SETTLE-1] : 7'($urandom);
      start1 = (c == 0);
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    chk("pre_rst_mask", int'(mask1), 1);
    rst = 1'b1; #1;
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_done", int'(done1), 0);
    chk("midrst_pass", int'(pass1), 0);
    chk("midrst_mask", int'(mask1), 0);
    chk("midrst_samp", int'(samp1), 0);
    q1.delete();
    while (cyc < k + 5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      flags = EXP1;
      @(posedge clk); #1;
    end
    chk("post_rst_idle", int'(busy1), 0);
    fill(EXP1); run(1'b1, 1'b0);

    // Randomized runs on both instances.
    for (int r = 0; r < 10; r++) begin
      logic [6:0] ev;
      bit sel;
      sel = r[0];
      ev  = sel ? EXP1 : EXP0;
      for (int i = 0; i < TIMEOUT; i++)
        seq[i] = ($urandom_range(0, 3) != 0) ? ev : ev ^ 7'($urandom_range(1, 127));
      run(sel, bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
